alu_seq: RTL and testbench

- Parametrised, registered successor to the 8-bit add/subtract ALU in the CPU datapath.
- Adds a WIDTH generic, logic and shift operations, extra status flags, and an optional multi-cycle shift-add multiplier.
- Result is held in an internal result register and driven onto the shared BUS under an active-low output enable.
- Flags feed the control sequencer for conditional jumps.

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu_mul_seq.sv | 53 +++++
 rtl/alu_seq.sv | 163 ++++++++++++++++
 tb/tb_alu_seq.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and flag-index definitions for the sequential ALU.
package alu_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MULT = 1'b1
  } state_e;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;
  localparam int FLG_V = 3;
  localparam int FLG_W = 4;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one multiplier bit per clock, WIDTH clocks per product.
module alu_mul_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] mcand_p0;
  logic [2*WIDTH-1:0] acc_p0;
  logic [2*WIDTH-1:0] acc_d;
  logic [WIDTH-1:0]   mplier_p0;
  logic [CNT_W-1:0]   cnt_p0;

  // Final product is presented combinationally on the last iteration so the
  // caller can register it on the same edge the multiplier goes idle.
  always_comb acc_d = acc_p0 + (mplier_p0[0] ? mcand_p0 : '0);

  assign done    = busy && (cnt_p0 == LAST);
  assign product = acc_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      cnt_p0    <= '0;
      mcand_p0  <= '0;
      mplier_p0 <= '0;
      acc_p0    <= '0;
    end else if (start) begin
      busy      <= 1'b1;
      cnt_p0    <= '0;
      mcand_p0  <= {{WIDTH{1'b0}}, a};
      mplier_p0 <= b;
      acc_p0    <= '0;
    end else if (busy) begin
      acc_p0    <= acc_d;
      mcand_p0  <= mcand_p0 << 1;
      mplier_p0 <= mplier_p0 >> 1;
      cnt_p0    <= cnt_p0 + 1'b1;
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with status flags, optional sequential multiplier,
// and an active-low tri-state drive of the result onto the shared bus.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       OP,
  input  logic             GO,
  input  logic             FI,
  input  logic             EO_n,
  output logic [WIDTH-1:0] BUS,
  output logic [WIDTH-1:0] HI,
  output logic             BUSY,
  output logic             DONE,
  output logic             CF,
  output logic             ZF,
  output logic             NF,
  output logic             VF
);

  localparam int MSB = WIDTH - 1;

  state_e state_q, state_d;

  logic signed [WIDTH-1:0] a_s, b_s;
  logic [WIDTH:0]          sum;
  logic [WIDTH-1:0]        alu_res;
  logic                    alu_c, alu_v;

  logic                    single_go, mul_start;
  logic                    mul_busy, mul_done;
  logic [2*WIDTH-1:0]      product;

  logic [WIDTH-1:0]        res_p1, hi_p1;
  logic [FLG_W-1:0]        flg_p1;
  logic                    vld_p1;
  logic                    fi_p0;

  function automatic logic [FLG_W-1:0] flags_f(input logic [WIDTH-1:0] r,
                                               input logic c, input logic v);
    logic [FLG_W-1:0] f;
    f        = '0;
    f[FLG_C] = c;
    f[FLG_Z] = (r == '0);
    f[FLG_N] = r[MSB];
    f[FLG_V] = v;
    return f;
  endfunction

  assign a_s = $signed(A);
  assign b_s = $signed(B);

  always_comb begin
    sum     = '0;
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (OP)
      OP_ADD: begin
        sum     = {1'b0, A} + {1'b0, B};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_s[MSB] == b_s[MSB]) && (alu_res[MSB] != a_s[MSB]);
      end
      OP_SUB: begin
        // Carry out of A + ~B + 1: set means no borrow.
        sum     = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum[MSB:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_s[MSB] != b_s[MSB]) && (alu_res[MSB] != a_s[MSB]);
      end
      OP_AND: alu_res = A & B;
      OP_OR:  alu_res = A | B;
      OP_XOR: alu_res = A ^ B;
      OP_SHL: begin
        alu_res = A << 1;
        alu_c   = A[MSB];
      end
      OP_SHR: begin
        alu_res = A >> 1;
        alu_c   = A[0];
      end
      default: ;
    endcase
  end

  assign single_go = (state_q == ST_IDLE) && GO && (OP != OP_MUL);
  assign mul_start = (state_q == ST_IDLE) && GO && (OP == OP_MUL) && MUL_EN;

  generate
    if (MUL_EN) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (CLK),
        .rst     (CLR),
        .start   (mul_start),
        .a       (A),
        .b       (B),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (product)
      );
    end else begin : g_no_mul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign product  = '0;
    end
  endgenerate

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (mul_start) state_d = ST_MULT;
      ST_MULT: if (mul_done || !mul_busy) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Stage p1: result, high half, flags and completion strobe.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      res_p1 <= '0;
      hi_p1  <= '0;
      flg_p1 <= '0;
      vld_p1 <= 1'b0;
      fi_p0  <= 1'b0;
    end else begin
      vld_p1 <= 1'b0;
      if (mul_start) fi_p0 <= FI;
      if (single_go) begin
        res_p1 <= alu_res;
        hi_p1  <= '0;
        vld_p1 <= 1'b1;
        if (FI) flg_p1 <= flags_f(alu_res, alu_c, alu_v);
      end else if (mul_done) begin
        res_p1 <= product[MSB:0];
        hi_p1  <= product[2*WIDTH-1:WIDTH];
        vld_p1 <= 1'b1;
        if (fi_p0) flg_p1 <= flags_f(product[MSB:0], |product[2*WIDTH-1:WIDTH], 1'b0);
      end
    end
  end

  assign BUS  = EO_n ? {WIDTH{1'bz}} : res_p1;
  assign HI   = hi_p1;
  assign BUSY = (state_q == ST_MULT);
  assign DONE = vld_p1;
  assign CF   = flg_p1[FLG_C];
  assign ZF   = flg_p1[FLG_Z];
  assign NF   = flg_p1[FLG_N];
  assign VF   = flg_p1[FLG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: arithmetic reference model checked every cycle, plus
// directed vectors with hand-computed results for an 8-bit and a 16-bit no-MUL build.
module tb_alu_seq;

  logic       CLK = 1'b0;
  logic       CLR = 1'b1;
  logic [7:0] A = '0, B = '0;
  logic [2:0] OP = '0;
  logic       GO = 1'b0, FI = 1'b0, EO_n = 1'b0;
  wire  [7:0] BUS;
  logic [7:0] HI;
  logic       BUSY, DONE, CF, ZF, NF, VF;

  logic [15:0] A16 = '0, B16 = '0;
  logic [2:0]  OP16 = '0;
  logic        GO16 = 1'b0, FI16 = 1'b0, EO16_n = 1'b0;
  wire  [15:0] BUS16;
  logic [15:0] HI16;
  logic        BUSY16, DONE16, CF16, ZF16, NF16, VF16;

  int n_vec = 0;
  int n_bad = 0;

  alu_seq #(.WIDTH(8), .MUL_EN(1'b1)) dut (
    .CLK(CLK), .CLR(CLR), .A(A), .B(B), .OP(OP), .GO(GO), .FI(FI), .EO_n(EO_n),
    .BUS(BUS), .HI(HI), .BUSY(BUSY), .DONE(DONE), .CF(CF), .ZF(ZF), .NF(NF), .VF(VF)
  );

  alu_seq #(.WIDTH(16), .MUL_EN(1'b0)) dut16 (
    .CLK(CLK), .CLR(CLR), .A(A16), .B(B16), .OP(OP16), .GO(GO16), .FI(FI16), .EO_n(EO16_n),
    .BUS(BUS16), .HI(HI16), .BUSY(BUSY16), .DONE(DONE16), .CF(CF16), .ZF(ZF16), .NF(NF16),
    .VF(VF16)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on the 8-bit operands.
  function automatic void golden(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] r, output logic [7:0] h,
                                 output logic c, output logic v);
    int ua, ub, sa, sb, t, s;
    ua = a; ub = b; sa = $signed(a); sb = $signed(b);
    t = 0; s = 0; h = 8'h00; c = 1'b0; v = 1'b0; r = 8'h00;
    case (op)
      3'd0: begin t = ua + ub; r = t[7:0]; c = (t > 255); s = sa + sb; v = (s > 127) || (s < -128); end
      3'd1: begin t = ua - ub; r = t[7:0]; c = (ua >= ub); s = sa - sb; v = (s > 127) || (s < -128); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: begin t = ua * 2; r = t[7:0]; c = (ua >= 128); end
      3'd6: begin t = ua / 2; r = t[7:0]; c = (ua % 2) == 1; end
      default: begin t = ua * ub; r = t[7:0]; h = t[15:8]; c = (h != 8'h00); end
    endcase
  endfunction

  logic [7:0] m_res = '0, m_hi = '0, p_res = '0, p_hi = '0;
  logic       m_c = 0, m_z = 0, m_n = 0, m_v = 0, m_busy = 0, m_done = 0;
  logic       p_c = 0, p_v = 0, p_fi = 0;
  int         m_left = 0;

  task automatic commit(input logic [7:0] r, input logic [7:0] h, input logic c,
                        input logic v, input logic fi);
    m_res = r; m_hi = h; m_done = 1'b1;
    if (fi) begin m_c = c; m_v = v; m_z = (r == 8'h00); m_n = (r >= 8'h80); end
  endtask

  always @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      m_res = '0; m_hi = '0; m_c = 0; m_z = 0; m_n = 0; m_v = 0;
      m_busy = 0; m_done = 0; m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          commit(p_res, p_hi, p_c, p_v, p_fi);
        end
      end else if (GO) begin
        golden(OP, A, B, p_res, p_hi, p_c, p_v);
        if (OP == 3'd7) begin
          m_busy = 1'b1; m_left = 8; p_fi = FI;
        end else begin
          commit(p_res, 8'h00, p_c, p_v, FI);
        end
      end
    end
  end

  always @(negedge CLK) begin
    if (!EO_n) chk("m_bus", {24'h0, BUS}, {24'h0, m_res});
    chk("m_hi",   {24'h0, HI}, {24'h0, m_hi});
    chk("m_busy", {31'h0, BUSY}, {31'h0, m_busy});
    chk("m_done", {31'h0, DONE}, {31'h0, m_done});
    chk("m_flags", {28'h0, VF, NF, ZF, CF}, {28'h0, m_v, m_n, m_z, m_c});
  end

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic fi);
    OP = op; A = a; B = b; FI = fi; GO = 1'b1;
    @(posedge CLK); #1;
    GO = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic [7:0] bus, input logic [7:0] hi,
                         input logic [3:0] vnzc, input logic done);
    chk({nm, "_bus"},  {24'h0, BUS}, {24'h0, bus});
    chk({nm, "_hi"},   {24'h0, HI}, {24'h0, hi});
    chk({nm, "_flags"}, {28'h0, VF, NF, ZF, CF}, {28'h0, vnzc});
    chk({nm, "_done"}, {31'h0, DONE}, {31'h0, done});
  endtask

  initial begin
    logic seen;
    repeat (2) @(posedge CLK);
    #1;
    chk_out("reset", 8'h00, 8'h00, 4'b0000, 1'b0);
    chk("reset_busy", {31'h0, BUSY}, 32'h0);
    chk("reset_bus16", {16'h0, BUS16}, 32'h0);
    CLR = 1'b0;

    issue(3'd0, 8'h7F, 8'h01, 1'b1);
    chk_out("add_ovf", 8'h80, 8'h00, 4'b1100, 1'b1);
    @(posedge CLK); #1;
    chk("add_done_pulse", {31'h0, DONE}, 32'h0);

    issue(3'd1, 8'h05, 8'h05, 1'b1);
    chk_out("sub_zero", 8'h00, 8'h00, 4'b0011, 1'b1);
    issue(3'd1, 8'h05, 8'h06, 1'b0);
    chk_out("sub_nofi", 8'hFF, 8'h00, 4'b0011, 1'b1);

    issue(3'd5, 8'h81, 8'h55, 1'b1);
    chk_out("shl", 8'h02, 8'h00, 4'b0001, 1'b1);
    issue(3'd6, 8'h81, 8'hAA, 1'b1);
    chk_out("shr", 8'h40, 8'h00, 4'b0001, 1'b1);

    issue(3'd7, 8'hFF, 8'hFF, 1'b1);
    chk("mul_busy_0", {31'h0, BUSY}, 32'h1);
    for (int i = 1; i <= 7; i++) begin
      if (i == 2 || i == 5) begin OP = 3'd0; A = 8'h01; B = 8'h01; GO = 1'b1; end
      else GO = 1'b0;
      @(posedge CLK); #1;
      chk("mul_busy", {31'h0, BUSY}, 32'h1);
      chk("mul_nodone", {31'h0, DONE}, 32'h0);
      chk("mul_hold_bus", {24'h0, BUS}, 32'h40);
    end
    GO = 1'b0;
    @(posedge CLK); #1;
    chk_out("mul_ff", 8'h01, 8'hFE, 4'b0001, 1'b1);
    chk("mul_busy_drop", {31'h0, BUSY}, 32'h0);

    issue(3'd2, 8'hF0, 8'hBC, 1'b1);
    chk_out("and_clr_hi", 8'hB0, 8'h00, 4'b0100, 1'b1);

    issue(3'd7, 8'h10, 8'h10, 1'b1);
    repeat (8) @(posedge CLK);
    #1;
    chk_out("mul_10", 8'h00, 8'h01, 4'b0011, 1'b1);

    EO_n = 1'b1;
    issue(3'd7, 8'h0F, 8'h0F, 1'b1);
    repeat (3) @(posedge CLK);
    #1;
    CLR = 1'b1;
    #1;
    chk_out("abort", 8'h00, 8'h00, 4'b0000, 1'b0);
    chk("abort_busy", {31'h0, BUSY}, 32'h0);
    @(posedge CLK); #1;
    CLR = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge CLK); #1;
      if (DONE || BUSY) seen = 1'b1;
    end
    chk("abort_no_done", {31'h0, seen}, 32'h0);
    EO_n = 1'b0;
    #1;
    chk("abort_bus", {24'h0, BUS}, 32'h0);

    issue(3'd4, 8'hA5, 8'h0F, 1'b1);
    for (int i = 0; i < 4; i++) begin
      EO_n = ~EO_n; #2;
    end
    @(posedge CLK); #1;
    EO_n = 1'b0;
    #1;
    chk_out("eo_toggle", 8'hAA, 8'h00, 4'b0100, 1'b0);

    A16 = 16'hFFFF; B16 = 16'h0001; OP16 = 3'd0; FI16 = 1'b1; GO16 = 1'b1;
    @(posedge CLK); #1;
    GO16 = 1'b0;
    chk("w16_add_bus", {16'h0, BUS16}, 32'h0);
    chk("w16_add_flags", {28'h0, VF16, NF16, ZF16, CF16}, 32'h3);
    chk("w16_add_done", {31'h0, DONE16}, 32'h1);
    A16 = 16'h0003; B16 = 16'h0005; OP16 = 3'd7; GO16 = 1'b1;
    @(posedge CLK); #1;
    GO16 = 1'b0;
    chk("w16_mul_done", {31'h0, DONE16}, 32'h0);
    chk("w16_mul_busy", {31'h0, BUSY16}, 32'h0);
    chk("w16_mul_bus", {16'h0, BUS16}, 32'h0);
    chk("w16_mul_hi", {16'h0, HI16}, 32'h0);
    chk("w16_mul_flags", {28'h0, VF16, NF16, ZF16, CF16}, 32'h3);
    @(posedge CLK); #1;
    chk("w16_mul_done2", {31'h0, DONE16}, 32'h0);
    chk("w16_mul_busy2", {31'h0, BUSY16}, 32'h0);

    repeat (2) @(posedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
